// File: rtl/ro_puf_top.sv
// ro_puf_top: deterministic ring-oscillator PUF model.
// Each emulated RO is an 8-bit phase accumulator. Its carry-outs are counted
// over a WINDOW-cycle measurement. Response bit i is (cnt[2i] > cnt[2i+1]).
// Optional macro RO_PUF_VALID_EN adds a response_valid output.

// One emulated ring oscillator: phase accumulator plus saturating edge counter.
module ro_puf_lane #(
  parameter logic [7:0] INC = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_step,
  output logic [7:0] o_cnt
);
  logic [7:0] r_acc;
  logic [7:0] r_cnt;
  logic [8:0] w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, INC};
  assign o_cnt = r_cnt;

  // Advance phase each step and count carry-outs, saturating at 255.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_step) begin
      r_acc <= w_sum[7:0];
      if (w_sum[8] && (r_cnt != 8'hFF)) r_cnt <= r_cnt + 8'd1;
    end
  end
endmodule

module ro_puf_top #(
  parameter int                        NUM_PAIRS = 4,
  parameter int                        WINDOW    = 64,
  parameter logic [16*NUM_PAIRS-1:0]   RO_INC    = 64'h250D0B1F1D111317
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
`ifdef RO_PUF_VALID_EN
  output logic                 response_valid,
`endif
  output logic [NUM_PAIRS-1:0] puf_response
);
  localparam int         NUM_RO   = 2 * NUM_PAIRS;
  localparam logic [7:0] WIN_LAST = 8'(WINDOW - 1);

  typedef enum logic [1:0] {IDLE, MEASURE, COMPARE, DONE} state_t;

  state_t                     r_state;
  logic [7:0]                 r_win;
  logic [NUM_PAIRS-1:0]       r_resp;
  logic [NUM_RO-1:0][7:0]     w_cnt;
  logic [NUM_PAIRS-1:0]       w_cmp;
  logic                       w_clr;
  logic                       w_step;

  // Counts are cleared on every start so repeated measurements are identical;
  // a step only happens while enable holds, an abort edge does not accumulate.
  assign w_clr  = (r_state == IDLE) && enable;
  assign w_step = (r_state == MEASURE) && enable;

  genvar k;
  generate
    for (k = 0; k < NUM_RO; k++) begin : g_ro
      ro_puf_lane #(.INC(RO_INC[8*k +: 8])) u_lane (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_clr),
        .i_step (w_step),
        .o_cnt  (w_cnt[k])
      );
    end
    for (k = 0; k < NUM_PAIRS; k++) begin : g_cmp
      assign w_cmp[k] = (w_cnt[2*k] > w_cnt[2*k+1]);
    end
  endgenerate

  // Measurement sequencer; the response register only moves on COMPARE or reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_win   <= '0;
      r_resp  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state <= MEASURE;
            r_win   <= '0;
          end
        end
        MEASURE: begin
          if (!enable) begin
            r_state <= IDLE;
          end else begin
            r_win <= r_win + 8'd1;
            if (r_win == WIN_LAST) r_state <= COMPARE;
          end
        end
        COMPARE: begin
          r_resp  <= w_cmp;
          r_state <= DONE;
        end
        DONE: begin
          if (!enable) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign puf_response = r_resp;

`ifdef RO_PUF_VALID_EN
  logic r_vld;

  // Valid drops at each start and rises only when a measurement completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
    end else if (r_state == IDLE && enable) begin
      r_vld <= 1'b0;
    end else if (r_state == COMPARE) begin
      r_vld <= 1'b1;
    end
  end

  assign response_valid = r_vld;
`endif
endmodule

// File: tb/tb_ro_puf_top.sv
// Directed bench for ro_puf_top: reset, nominal latency, hold, abort,
// tie/reconfigured increments and reset mid-measurement.
module tb_ro_puf_top;
  logic       clk;
  logic       rst;
  logic       enable;
  logic [3:0] resp;
  logic [3:0] resp2;
`ifdef RO_PUF_VALID_EN
  logic       vld;
  logic       vld2;
`endif
  int         ncmp;
  int         nfail;

  // Default increments: counts 5,4,4,7,7,2,3,9 -> 4'b0101.
  ro_puf_top dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
`ifdef RO_PUF_VALID_EN
    .response_valid (vld),
`endif
    .puf_response (resp)
  );

  // Pair0 0x40/0x40 -> 16 vs 16 (tie, 0); pair1 0x80/0x10 -> 32 vs 4 (1);
  // pairs 2,3 zero increments -> ties. Expected 4'b0010.
  ro_puf_top #(.RO_INC(64'h0000_0000_1080_4040)) dut2 (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
`ifdef RO_PUF_VALID_EN
    .response_valid (vld2),
`endif
    .puf_response (resp2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // E0 already taken by caller; waits E1..E64 expecting 'pre', then E65.
  task automatic measure(input string tag, input logic [3:0] pre);
    for (int k = 1; k <= 64; k++) begin
      tick();
      chk({tag, "_pre"}, resp, pre);
`ifdef RO_PUF_VALID_EN
      chk({tag, "_vld_pre"}, {3'b0, vld}, 4'b0000);
`endif
    end
    tick();
    chk({tag, "_res"}, resp, 4'b0101);
    chk({tag, "_res_tie"}, resp2, 4'b0010);
`ifdef RO_PUF_VALID_EN
    chk({tag, "_vld"}, {3'b0, vld}, 4'b0001);
`endif
  endtask

  initial begin
    ncmp   = 0;
    nfail  = 0;
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);

    // Reset
    tick(); tick();
    chk("reset", resp, 4'b0000);
    chk("reset_tie", resp2, 4'b0000);
`ifdef RO_PUF_VALID_EN
    chk("reset_vld", {3'b0, vld}, 4'b0000);
`endif

    // Nominal: enable high 100 cycles
    rst    = 1'b0;
    enable = 1'b1;
    tick();                      // E0
    measure("nominal", 4'b0000);
    for (int k = 0; k < 34; k++) tick();
    chk("nominal_hold", resp, 4'b0101);

    // Hold through enable low, then remeasure
    enable = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("hold_low", resp, 4'b0101);
    end
    enable = 1'b1;
    tick();                      // E0
    measure("remeasure", 4'b0101);

    // Abort after 30 cycles from a fresh reset
    rst = 1'b1; enable = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("abort_rst", resp, 4'b0000);
    enable = 1'b1;
    tick();                      // E0
    for (int k = 0; k < 30; k++) tick();
    enable = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("abort_unchanged", resp, 4'b0000);
    chk("abort_unchanged_tie", resp2, 4'b0000);
`ifdef RO_PUF_VALID_EN
    chk("abort_vld", {3'b0, vld}, 4'b0000);
`endif
    enable = 1'b1;
    tick();                      // E0
    measure("after_abort", 4'b0000);

    // Reset mid-measurement at cycle 40
    enable = 1'b0;
    tick();
    enable = 1'b1;
    tick();                      // E0
    for (int k = 0; k < 40; k++) tick();
    chk("mid_before_rst", resp, 4'b0101);
    rst = 1'b1;
    tick();
    chk("mid_rst", resp, 4'b0000);
    chk("mid_rst_tie", resp2, 4'b0000);
`ifdef RO_PUF_VALID_EN
    chk("mid_rst_vld", {3'b0, vld}, 4'b0000);
`endif
    // Fresh start straight out of reset with enable already high
    rst = 1'b0;
    tick();                      // E0
    measure("post_rst", 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
